sys_bridge: RTL and testbench

//  Data-side slave that sits directly downstream of the CPU's M stage.

---
 rtl/sys_bridge_pkg.sv | 25 ++
 rtl/sys_bridge_if.sv | 24 ++
 rtl/sys_timer.sv | 91 +++++++++
 rtl/sys_bridge.sv | 60 ++++++
 tb/tb_sys_bridge.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_bridge_pkg.sv
// Address map, CTRL field positions and timer state encoding shared by
// the data-side bridge and its countdown timer.
package sys_bridge_pkg;

   localparam int unsigned DM_WORDS_DFLT   = 3072;
   localparam logic [31:0] TIMER_BASE_DFLT = 32'h0000_7F00;

   localparam logic [31:0] OFS_CTRL   = 32'h0;
   localparam logic [31:0] OFS_PRESET = 32'h4;
   localparam logic [31:0] OFS_COUNT  = 32'h8;

   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_MODE_LO = 1;
   localparam int unsigned CTRL_IM      = 3;

   localparam logic [1:0] MODE_RELOAD = 2'b01;

   typedef enum logic [1:0] {
      T_IDLE,
      T_LOAD,
      T_CNT,
      T_INT
   } timer_state_e;

endpackage

// File: rtl/sys_bridge_if.sv
// M-stage data bus: byte address, lane-aligned write data, byte enables and
// combinational read data.
interface sys_bridge_if;

   logic [31:0] m_data_addr;
   logic [31:0] m_data_wdata;
   logic [3:0]  m_data_byteen;
   logic [31:0] m_data_rdata;

   modport master (
      output m_data_addr,
      output m_data_wdata,
      output m_data_byteen,
      input  m_data_rdata
   );

   modport slave (
      input  m_data_addr,
      input  m_data_wdata,
      input  m_data_byteen,
      output m_data_rdata
   );

endinterface

// File: rtl/sys_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, a four-state
// sequencer and a level interrupt gated by CTRL.IM.
module sys_timer
   import sys_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_ctrl,
   input  logic        wr_preset,
   input  logic [31:0] wdata,
   output logic [31:0] ctrl_rd,
   output logic [31:0] preset,
   output logic [31:0] count,
   output logic        irq
);

   timer_state_e state, state_nx;
   logic         en, en_nx;
   logic [1:0]   mode;
   logic         im;
   logic         pending, pending_nx;
   logic [31:0]  count_nx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= T_IDLE;
         en      <= 1'b0;
         mode    <= '0;
         im      <= 1'b0;
         preset  <= '0;
         count   <= '0;
         pending <= 1'b0;
      end else begin
         state   <= state_nx;
         en      <= en_nx;
         count   <= count_nx;
         pending <= pending_nx;
         if (wr_ctrl) begin
            mode <= wdata[CTRL_MODE_LO +: 2];
            im   <= wdata[CTRL_IM];
         end
         if (wr_preset) begin
            preset <= wdata;
         end
      end
   end

   always_comb begin
      state_nx   = state;
      en_nx      = en;
      count_nx   = count;
      pending_nx = pending;
      unique case (state)
         T_IDLE: if (en) state_nx = T_LOAD;
         T_LOAD: begin
            count_nx = preset;
            state_nx = T_CNT;
         end
         T_CNT: begin
            if (!en) begin
               state_nx = T_IDLE;
            end else if (count > 32'd1) begin
               count_nx = count - 32'd1;
            end else begin
               count_nx   = '0;
               pending_nx = 1'b1;
               state_nx   = T_INT;
            end
         end
         T_INT: begin
            if (mode == MODE_RELOAD) begin
               state_nx = T_LOAD;
            end else begin
               en_nx    = 1'b0;
               state_nx = T_IDLE;
            end
         end
         default: state_nx = T_IDLE;
      endcase
      // A bus write to CTRL overrides whatever the sequencer decided this edge.
      if (wr_ctrl) begin
         en_nx      = wdata[CTRL_EN];
         pending_nx = 1'b0;
         if (!wdata[CTRL_EN]) state_nx = T_IDLE;
      end
   end

   assign ctrl_rd = {28'b0, im, mode, en};
   assign irq     = pending & im;

endmodule

// File: rtl/sys_bridge.sv
// Data-side slave for the M stage: decodes the byte address into the data
// RAM or the timer window and returns read data in the same cycle.
module sys_bridge
   import sys_bridge_pkg::*;
#(
   parameter int unsigned DM_WORDS   = DM_WORDS_DFLT,
   parameter logic [31:0] TIMER_BASE = TIMER_BASE_DFLT
)(
   input  logic         clk,
   input  logic         reset,
   sys_bridge_if.slave  bus,
   output logic         irq_timer
);

   localparam int unsigned AW = $clog2(DM_WORDS);

   logic [31:0]   word_addr;
   logic          ram_sel, ctrl_sel, preset_sel, count_sel, full_word;
   logic [AW-1:0] widx;
   logic [31:0]   ctrl_rd, preset_rd, count_rd;

   logic [31:0] mem [DM_WORDS] = '{default: '0};

   assign word_addr  = {bus.m_data_addr[31:2], 2'b00};
   assign ram_sel    = bus.m_data_addr < 32'(4 * DM_WORDS);
   assign ctrl_sel   = word_addr == TIMER_BASE + OFS_CTRL;
   assign preset_sel = word_addr == TIMER_BASE + OFS_PRESET;
   assign count_sel  = word_addr == TIMER_BASE + OFS_COUNT;
   assign full_word  = bus.m_data_byteen == 4'hF;
   assign widx       = bus.m_data_addr[AW+1:2];

   always_ff @(posedge clk) begin
      if (ram_sel) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (bus.m_data_byteen[i]) mem[widx][8*i +: 8] <= bus.m_data_wdata[8*i +: 8];
         end
      end
   end

   sys_timer u_timer (
      .clk       (clk),
      .reset     (reset),
      .wr_ctrl   (ctrl_sel & full_word),
      .wr_preset (preset_sel & full_word),
      .wdata     (bus.m_data_wdata),
      .ctrl_rd   (ctrl_rd),
      .preset    (preset_rd),
      .count     (count_rd),
      .irq       (irq_timer)
   );

   always_comb begin
      bus.m_data_rdata = '0;
      if (ram_sel)         bus.m_data_rdata = mem[widx];
      else if (ctrl_sel)   bus.m_data_rdata = ctrl_rd;
      else if (preset_sel) bus.m_data_rdata = preset_rd;
      else if (count_sel)  bus.m_data_rdata = count_rd;
   end

endmodule

// File: tb/tb_sys_bridge.sv
// Randomised and directed bench for sys_bridge against a behavioural model
// of the address map, data RAM and countdown timer.
module tb_sys_bridge;

   localparam logic [31:0] A_CTRL   = 32'h7F00;
   localparam logic [31:0] A_PRESET = 32'h7F04;
   localparam logic [31:0] A_COUNT  = 32'h7F08;
   localparam int P_IDLE = 0, P_LOAD = 1, P_CNT = 2, P_INT = 3;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic irq_timer;
   int   checks = 0;
   int   errors = 0;

   sys_bridge_if bus ();

   sys_bridge dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .irq_timer (irq_timer)
   );

   always #5 clk = ~clk;

   // behavioural model
   logic [31:0] m_mem [3072];
   logic        m_en, m_im, m_pend;
   logic [1:0]  m_mode;
   logic [31:0] m_preset, m_count;
   int          m_ph;
   logic [31:0] last_rd;
   logic        last_irq;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_en = 0; m_im = 0; m_pend = 0; m_mode = 0;
      m_preset = 0; m_count = 0; m_ph = P_IDLE;
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a);
      logic [31:0] wa = a & ~32'h3;
      if (a < 32'h3000)      return m_mem[a[13:2]];
      if (wa == A_CTRL)      return {28'b0, m_im, m_mode, m_en};
      if (wa == A_PRESET)    return m_preset;
      if (wa == A_COUNT)     return m_count;
      return 32'h0;
   endfunction

   // One clock edge of the model, using pre-edge values throughout.
   task automatic m_step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] wa = a & ~32'h3;
      bit wc = (wa == A_CTRL) && (be == 4'hF);
      bit wp = (wa == A_PRESET) && (be == 4'hF);
      int nph = m_ph;
      logic [31:0] ncnt = m_count;
      logic npend = m_pend, nen = m_en;
      case (m_ph)
         P_IDLE: if (m_en) nph = P_LOAD;
         P_LOAD: begin ncnt = m_preset; nph = P_CNT; end
         P_CNT: begin
            if (!m_en) nph = P_IDLE;
            else if (m_count > 1) ncnt = m_count - 1;
            else begin ncnt = 0; npend = 1; nph = P_INT; end
         end
         default: begin
            if (m_mode == 2'b01) nph = P_LOAD;
            else begin nen = 0; nph = P_IDLE; end
         end
      endcase
      if (wc) begin
         nen = d[0]; npend = 0;
         if (!d[0]) nph = P_IDLE;
         m_mode = d[2:1]; m_im = d[3];
      end
      if (wp) m_preset = d;
      m_ph = nph; m_count = ncnt; m_pend = npend; m_en = nen;
      if (a < 32'h3000)
         for (int i = 0; i < 4; i++)
            if (be[i]) m_mem[a[13:2]][8*i +: 8] = d[8*i +: 8];
   endtask

   // Present one bus beat, check combinational outputs, then clock it in.
   task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input string tag);
      bus.m_data_addr = a; bus.m_data_wdata = d; bus.m_data_byteen = be;
      #1;
      last_rd  = bus.m_data_rdata;
      last_irq = irq_timer;
      check({tag, ".rd"}, last_rd, m_read(a));
      check({tag, ".irq"}, {31'b0, last_irq}, {31'b0, m_pend & m_im});
      @(posedge clk);
      m_step(a, d, be);
      @(negedge clk);
   endtask

   logic [31:0] cnt_seen [16];
   logic        irq_seen [16];

   initial begin
      for (int i = 0; i < 3072; i++) m_mem[i] = '0;
      m_reset();
      bus.m_data_addr = 32'h0; bus.m_data_wdata = 32'h0; bus.m_data_byteen = 4'h0;
      #1;
      check("rst.irq", {31'b0, irq_timer}, 32'h0);
      bus.m_data_addr = A_COUNT; #1;
      check("rst.count", bus.m_data_rdata, 32'h0);
      bus.m_data_addr = A_CTRL; #1;
      check("rst.ctrl", bus.m_data_rdata, 32'h0);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // RAM byte lanes
      cyc(32'h10, 32'h1122_3344, 4'hF, "ram.sw");
      cyc(32'h10, 32'h00AA_0000, 4'b0100, "ram.sb");
      cyc(32'h10, 32'h0, 4'h0, "ram.rd");
      check("ram.lane", last_rd, 32'h11AA_3344);

      // unmapped window
      cyc(32'h5000, 32'hDEAD, 4'hF, "unm.wr");
      cyc(32'h5000, 32'h0, 4'h0, "unm.rd");
      check("unm.zero", last_rd, 32'h0);
      cyc(32'h10, 32'h0, 4'h0, "unm.ram");
      check("unm.ramkeep", last_rd, 32'h11AA_3344);

      // one-shot
      cyc(A_PRESET, 32'd3, 4'hF, "os.pre");
      cyc(A_CTRL, 32'h9, 4'hF, "os.ctrl");
      for (int k = 1; k <= 8; k++) begin
         cyc(A_COUNT, 32'h0, 4'h0, "os.run");
         cnt_seen[k] = last_rd; irq_seen[k] = last_irq;
      end
      check("os.c3", cnt_seen[3], 32'd3);
      check("os.c2", cnt_seen[4], 32'd2);
      check("os.c1", cnt_seen[5], 32'd1);
      check("os.c0", cnt_seen[6], 32'd0);
      check("os.irq5", {31'b0, irq_seen[5]}, 32'h0);
      check("os.irq6", {31'b0, irq_seen[6]}, 32'h1);
      cyc(A_CTRL, 32'h0, 4'h0, "os.ctrlrd");
      check("os.enclr", last_rd, 32'h8);
      cyc(A_CTRL, 32'h8, 4'hF, "os.ack");
      cyc(A_CTRL, 32'h0, 4'h0, "os.post");
      check("os.irqoff", {31'b0, last_irq}, 32'h0);

      // auto-reload
      cyc(A_PRESET, 32'd2, 4'hF, "ar.pre");
      cyc(A_CTRL, 32'hB, 4'hF, "ar.ctrl");
      for (int k = 1; k <= 10; k++) begin
         cyc(A_COUNT, 32'h0, 4'h0, "ar.run");
         cnt_seen[k] = last_rd; irq_seen[k] = last_irq;
      end
      check("ar.c2", cnt_seen[3], 32'd2);
      check("ar.c1", cnt_seen[4], 32'd1);
      check("ar.c0", cnt_seen[5], 32'd0);
      check("ar.reload", cnt_seen[7], 32'd2);
      check("ar.wrap", cnt_seen[9], 32'd0);
      check("ar.irq4", {31'b0, irq_seen[4]}, 32'h0);
      check("ar.irq5", {31'b0, irq_seen[5]}, 32'h1);
      cyc(A_PRESET, 32'd7, 4'h3, "ar.partial");
      cyc(A_PRESET, 32'h0, 4'h0, "ar.prerd");
      check("ar.prekeep", last_rd, 32'd2);

      // abort mid-count
      cyc(A_CTRL, 32'h0, 4'hF, "ab.stop");
      cyc(A_PRESET, 32'd5, 4'hF, "ab.pre");
      cyc(A_CTRL, 32'h9, 4'hF, "ab.go");
      for (int k = 1; k <= 3; k++) cyc(A_COUNT, 32'h0, 4'h0, "ab.run");
      cyc(A_CTRL, 32'h8, 4'hF, "ab.kill");
      for (int k = 1; k <= 8; k++) begin
         cyc(A_COUNT, 32'h0, 4'h0, "ab.hold");
         cnt_seen[k] = last_rd; irq_seen[k] = last_irq;
      end
      check("ab.frozen", cnt_seen[8], 32'd3);
      check("ab.noirq", {31'b0, irq_seen[8]}, 32'h0);

      // async reset mid-count with pending set
      cyc(A_PRESET, 32'd3, 4'hF, "rs.pre");
      cyc(A_CTRL, 32'hB, 4'hF, "rs.go");
      for (int k = 1; k <= 8; k++) cyc(A_COUNT, 32'h0, 4'h0, "rs.run");
      check("rs.irqpre", {31'b0, last_irq}, 32'h1);
      bus.m_data_byteen = 4'h0;
      bus.m_data_addr = A_COUNT;
      #2 reset = 1'b0;
      #1;
      check("rs.irq", {31'b0, irq_timer}, 32'h0);
      check("rs.count", bus.m_data_rdata, 32'h0);
      bus.m_data_addr = A_CTRL; #1;
      check("rs.ctrl", bus.m_data_rdata, 32'h0);
      bus.m_data_addr = 32'h10; #1;
      check("rs.ram", bus.m_data_rdata, 32'h11AA_3344);
      m_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // random traffic
      for (int n = 0; n < 600; n++) begin
         int unsigned r = $urandom_range(0, 11);
         logic [31:0] a, d;
         logic [3:0]  be;
         d  = $urandom;
         be = 4'h0;
         case (r)
            0, 1, 2: begin
               a  = (r == 2) ? 32'h2FF0 + $urandom_range(0, 15) : $urandom_range(0, 63);
               be = 4'($urandom_range(0, 15));
            end
            3: begin
               a  = ($urandom_range(0, 1) == 0) ? 32'h3000 + $urandom_range(0, 15) : 32'h7F0C;
               be = 4'hF;
            end
            4: begin
               a  = A_CTRL + $urandom_range(0, 3);
               d  = {28'($urandom), 4'($urandom_range(0, 15) | ($urandom_range(0, 2) != 0 ? 1 : 0))};
               be = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            end
            5: begin
               a  = A_PRESET;
               d  = $urandom_range(0, 6);
               be = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
            end
            6: begin
               a  = A_COUNT;
               be = 4'($urandom_range(0, 15));
            end
            7: a = A_CTRL;
            8: a = A_PRESET;
            9: a = 32'h5000;
            default: a = A_COUNT;
         endcase
         cyc(a, d, be, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

endmodule
